// File: rtl/al_accel_ctrl_gen2.sv
// al_accel_ctrl_gen2
//   PicoRV32-side control block for the Alpha accelerator. It decodes
//   memory-mapped writes into config-register selects/strobes and sequences
//   the datapath through IDLE -> CFG -> RUN -> FIN, with a timeout ERR state.
//   It also keeps a RUN-cycle counter, a STATUS register and an optional
//   level interrupt.
//
// Optional feature macro: AL_ACCEL_IRQ_EN
//   Defined   : irq_pending is set on entry to FIN or ERR. It is cleared by
//               command 0, command 4 or reset. al_accel_irq = irq_pending.
//   Undefined : al_accel_irq = 0, STATUS bit0 reads 0, command 4 does nothing.
//
// Register map (offsets from BASE_ADDR):
//   4*i              config register i (write only, i < NUM_CFG_REGS)
//   CTRL_OFFSET      CTRL    write wdata[2:0] = command, read = state
//   CTRL_OFFSET+4    STATUS  {timeout_flag, fin_flag, irq_pending}
//   CTRL_OFFSET+8    CYCLE   RUN cycle count (read only)
//   CTRL_OFFSET+12   TLIMIT  timeout limit, 0 = no timeout
//   Any other read address returns all-ones.
//
// Ports:
//   clk                   system clock
//   reset                 synchronous, active-high reset
//   al_accel_mem_valid    bus write qualifier
//   al_accel_ctrl_waddr   write address
//   al_accel_ctrl_wdata   write data
//   al_accel_ctrl_raddr   read address
//   al_accel_ctrl_rdata   read data (combinational)
//   al_accel_cal_fin      accelerator done pulse/level
//   al_accel_cfgreg_sel   config register index
//   al_accel_cfgreg_wenb  config write strobe
//   al_accel_flow_enb     datapath run enable
//   al_accel_flow_resetn  datapath reset, active-low
//   al_accel_irq          interrupt, level
module al_accel_ctrl_gen2 #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_1000,
  parameter int          NUM_CFG_REGS = 17,
  parameter int          SEL_W        = 5,
  parameter logic [31:0] CTRL_OFFSET  = 32'h50,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             al_accel_mem_valid,
  input  logic [31:0]      al_accel_ctrl_waddr,
  input  logic [31:0]      al_accel_ctrl_wdata,
  input  logic [31:0]      al_accel_ctrl_raddr,
  output logic [31:0]      al_accel_ctrl_rdata,
  input  logic             al_accel_cal_fin,
  output logic [SEL_W-1:0] al_accel_cfgreg_sel,
  output logic             al_accel_cfgreg_wenb,
  output logic             al_accel_flow_enb,
  output logic             al_accel_flow_resetn,
  output logic             al_accel_irq
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [31:0]      OFF_CTRL   = CTRL_OFFSET;
  localparam logic [31:0]      OFF_STATUS = CTRL_OFFSET + 32'd4;
  localparam logic [31:0]      OFF_CYCLE  = CTRL_OFFSET + 32'd8;
  localparam logic [31:0]      OFF_TLIMIT = CTRL_OFFSET + 32'd12;
  localparam logic [31:0]      CFG_SPAN   = 32'(4 * NUM_CFG_REGS);
  localparam logic [SEL_W-1:0] SEL_IDLE   = SEL_W'(NUM_CFG_REGS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cycle_cnt_reg;
  logic [CNT_W-1:0]   tlimit_reg;
  logic               fin_flag_reg;
  logic               timeout_flag_reg;
  logic               irq_pending;

  // Offsets relative to the block base. Addresses below the base wrap to
  // huge values, so they never decode.
  logic [31:0] waddr_off;
  logic [31:0] raddr_off;
  assign waddr_off = al_accel_ctrl_waddr - BASE_ADDR;
  assign raddr_off = al_accel_ctrl_raddr - BASE_ADDR;

  logic [2:0] cmd;
  logic       ctrl_wr;
  logic       tlimit_wr;
  logic       cfg_hit;
  logic       timeout_hit;
  logic       run_entry;

  assign cmd       = al_accel_ctrl_wdata[2:0];
  assign ctrl_wr   = al_accel_mem_valid && (waddr_off == OFF_CTRL);
  assign tlimit_wr = al_accel_mem_valid && (waddr_off == OFF_TLIMIT) &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_CFG));
  assign cfg_hit   = al_accel_mem_valid && (state_reg == ST_CFG) &&
                     (waddr_off[1:0] == 2'b00) && (waddr_off < CFG_SPAN);
  // The counter is 0 in the first RUN cycle, so TLIMIT-1 marks the
  // TLIMIT-th RUN cycle.
  assign timeout_hit = (tlimit_reg != '0) && (cycle_cnt_reg == tlimit_reg - CNT_ONE);
  assign run_entry   = (state_next == ST_RUN) && (state_reg != ST_RUN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // In RUN an accepted CTRL command outranks cal_fin, and cal_fin outranks
  // the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ctrl_wr && cmd == 3'd1)      state_next = ST_CFG;
        else if (ctrl_wr && cmd == 3'd2) state_next = ST_RUN;
      end
      ST_CFG: begin
        if (ctrl_wr && cmd == 3'd0)      state_next = ST_IDLE;
        else if (ctrl_wr && cmd == 3'd2) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (ctrl_wr && cmd == 3'd0) state_next = ST_IDLE;
        else if (al_accel_cal_fin)  state_next = ST_FIN;
        else if (timeout_hit)       state_next = ST_ERR;
      end
      ST_FIN, ST_ERR: begin
        if (ctrl_wr && cmd == 3'd0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    al_accel_flow_resetn = (state_reg != ST_IDLE);
    al_accel_flow_enb    = (state_reg == ST_RUN);
    al_accel_cfgreg_wenb = cfg_hit;
    al_accel_cfgreg_sel  = SEL_IDLE;
    if (cfg_hit) begin
      al_accel_cfgreg_sel = waddr_off[SEL_W+1:2];
    end
  end

  // Cycle counter. It counts only the RUN cycles that stay in RUN, so after
  // the exit CYCLE equals the number of RUN cycles before the exit cycle. It
  // holds outside RUN and saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
    end else if (run_entry) begin
      cycle_cnt_reg <= '0;
    end else if (state_reg == ST_RUN && state_next == ST_RUN && cycle_cnt_reg != '1) begin
      cycle_cnt_reg <= cycle_cnt_reg + CNT_ONE;
    end
  end

  // Completion flags. They are cleared when a new run starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      fin_flag_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else if (run_entry) begin
      fin_flag_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (state_next == ST_FIN) fin_flag_reg     <= 1'b1;
      if (state_next == ST_ERR) timeout_flag_reg <= 1'b1;
    end
  end

  // The timeout limit can change only while the datapath is parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      tlimit_reg <= '0;
    end else if (tlimit_wr) begin
      tlimit_reg <= al_accel_ctrl_wdata[CNT_W-1:0];
    end
  end

`ifdef AL_ACCEL_IRQ_EN
  logic irq_pending_reg;
  logic irq_set;
  logic irq_clr;

  // irq can be pending only in FIN/ERR, so a command 0 or 4 seen in any
  // state is a safe clear. Clear wins over a set in the same cycle.
  assign irq_clr = ctrl_wr && (cmd == 3'd0 || cmd == 3'd4);
  assign irq_set = (state_next != state_reg) &&
                   (state_next == ST_FIN || state_next == ST_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending_reg <= 1'b0;
    end else if (irq_clr) begin
      irq_pending_reg <= 1'b0;
    end else if (irq_set) begin
      irq_pending_reg <= 1'b1;
    end
  end

  assign irq_pending = irq_pending_reg;
`else
  assign irq_pending = 1'b0;
`endif

  assign al_accel_irq = irq_pending;

  // Counter and limit are zero-extended onto the 32-bit read bus.
  logic [31:0] cycle_rd;
  logic [31:0] tlimit_rd;
  if (CNT_W < 32) begin : g_rd_ext
    assign cycle_rd  = {{(32-CNT_W){1'b0}}, cycle_cnt_reg};
    assign tlimit_rd = {{(32-CNT_W){1'b0}}, tlimit_reg};
  end else begin : g_rd_full
    assign cycle_rd  = cycle_cnt_reg[31:0];
    assign tlimit_rd = tlimit_reg[31:0];
  end

  // Read mux. Only the four control registers are readable.
  always_comb begin
    al_accel_ctrl_rdata = 32'hFFFF_FFFF;
    if (raddr_off == OFF_CTRL) begin
      al_accel_ctrl_rdata = {29'd0, state_reg};
    end else if (raddr_off == OFF_STATUS) begin
      al_accel_ctrl_rdata = {29'd0, timeout_flag_reg, fin_flag_reg, irq_pending};
    end else if (raddr_off == OFF_CYCLE) begin
      al_accel_ctrl_rdata = cycle_rd;
    end else if (raddr_off == OFF_TLIMIT) begin
      al_accel_ctrl_rdata = tlimit_rd;
    end
  end

endmodule

// File: tb/tb_al_accel_ctrl_gen2.sv
// Self-checking bench for al_accel_ctrl_gen2. A directed walk through the
// test plan is followed by randomized bus traffic. Every cycle the outputs
// are compared with a behavioural model of the register map and sequencer.
module tb_al_accel_ctrl_gen2;

  localparam logic [31:0] B    = 32'h0200_1000;
  localparam int          NREG = 17;
`ifdef AL_ACCEL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [31:0] rdata;
  logic        cal_fin = 1'b0;
  logic [4:0]  cfg_sel;
  logic        cfg_wenb, flow_enb, flow_resetn, irq;

  al_accel_ctrl_gen2 dut (
    .clk                  (clk),
    .reset                (reset),
    .al_accel_mem_valid   (mem_valid),
    .al_accel_ctrl_waddr  (waddr),
    .al_accel_ctrl_wdata  (wdata),
    .al_accel_ctrl_raddr  (raddr),
    .al_accel_ctrl_rdata  (rdata),
    .al_accel_cal_fin     (cal_fin),
    .al_accel_cfgreg_sel  (cfg_sel),
    .al_accel_cfgreg_wenb (cfg_wenb),
    .al_accel_flow_enb    (flow_enb),
    .al_accel_flow_resetn (flow_resetn),
    .al_accel_irq         (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (0 IDLE, 1 CFG, 2 RUN, 3 FIN, 4 ERR)
  int          m_state;
  logic [31:0] m_cnt, m_tlim;
  bit          m_fin, m_to, m_irq;

  // Values sampled at the most recent negedge
  logic [31:0] cap_rdata;
  logic [31:0] cap_sel;
  bit          cap_wenb, cap_enb, cap_rstn, cap_irq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_tlim = 0; m_fin = 0; m_to = 0; m_irq = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [31:0] wa, input logic [31:0] wd,
                                     input bit cf);
    logic [31:0] off = wa - B;
    int  cmd = int'(wd[2:0]);
    bit  ctrl = v && (off == 32'h50);
    bit  tlw  = v && (off == 32'h5C) && (m_state == 0 || m_state == 1);
    int  ns = m_state;
    bit  clr, set;
    case (m_state)
      0: if (ctrl && cmd == 1) ns = 1; else if (ctrl && cmd == 2) ns = 2;
      1: if (ctrl && cmd == 0) ns = 0; else if (ctrl && cmd == 2) ns = 2;
      2: begin
        if (ctrl && cmd == 0) ns = 0;
        else if (cf) ns = 3;
        else if (m_tlim != 0 && m_cnt == m_tlim - 1) ns = 4;
      end
      default: if (ctrl && cmd == 0) ns = 0;
    endcase
    clr = ctrl && (cmd == 0 || cmd == 4);
    set = IRQ_EN && (ns != m_state) && (ns == 3 || ns == 4);
    if (ns == 2 && m_state != 2) begin
      m_cnt = 0; m_fin = 0; m_to = 0;
    end else if (m_state == 2 && ns == 2 && m_cnt != 32'hFFFF_FFFF) begin
      m_cnt = m_cnt + 1;
    end
    if (m_state == 2 && ns == 3) m_fin = 1;
    if (m_state == 2 && ns == 4) m_to = 1;
    if (clr) m_irq = 0; else if (set) m_irq = 1;
    if (tlw) m_tlim = wd;
    m_state = ns;
  endfunction

  // One bus cycle: drive, compare combinational outputs, then advance the model.
  task automatic step(input bit rst, input bit v, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] ra, input bit cf);
    logic [31:0] off, roff, exp_rd;
    bit          exp_wenb;
    int          exp_sel;
    reset = rst; mem_valid = v; waddr = wa; wdata = wd; raddr = ra; cal_fin = cf;
    @(negedge clk);
    off  = wa - B;
    roff = ra - B;
    exp_wenb = v && (m_state == 1) && (off[1:0] == 2'b00) && (off < 32'(4 * NREG));
    exp_sel  = exp_wenb ? int'(off >> 2) : NREG;
    case (roff)
      32'h50:  exp_rd = 32'(m_state);
      32'h54:  exp_rd = {29'd0, m_to, m_fin, IRQ_EN & m_irq};
      32'h58:  exp_rd = m_cnt;
      32'h5C:  exp_rd = m_tlim;
      default: exp_rd = 32'hFFFF_FFFF;
    endcase
    cap_rdata = rdata; cap_sel = 32'(cfg_sel); cap_wenb = cfg_wenb;
    cap_enb = flow_enb; cap_rstn = flow_resetn; cap_irq = irq;
    $display("[%0t] rst=%0b v=%0b wa=%h wd=%h ra=%h fin=%0b | rd=%h sel=%0d wenb=%0b enb=%0b rstn=%0b irq=%0b",
             $time, rst, v, wa, wd, ra, cf, rdata, cfg_sel, cfg_wenb, flow_enb, flow_resetn, irq);
    check_eq("rdata", rdata, exp_rd);
    check_eq("cfgreg_sel", 32'(cfg_sel), 32'(exp_sel));
    check_eq("cfgreg_wenb", 32'(cfg_wenb), 32'(exp_wenb));
    check_eq("flow_enb", 32'(flow_enb), 32'(m_state == 2));
    check_eq("flow_resetn", 32'(flow_resetn), 32'(m_state != 0));
    check_eq("irq", 32'(irq), 32'(IRQ_EN & m_irq));
    @(posedge clk);
    if (rst) model_reset();
    else model_step(v, wa, wd, cf);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, B + 32'h50, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b0, 32'h0, 32'h0, a, 1'b0);
  endtask

  task automatic run_idle(input int n, input bit cf);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, B + 32'h58, cf);
  endtask

  initial begin
    logic [31:0] ra, wa, wd;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rd(B + 32'h50);
    check_eq("rst_ctrl", cap_rdata, 32'h0);
    check_eq("rst_rstn", 32'(cap_rstn), 32'h0);
    check_eq("rst_sel", cap_sel, 32'd17);
    rd(B + 32'h100);
    check_eq("rst_unmapped", cap_rdata, 32'hFFFF_FFFF);

    // Config-register strobes in CFG
    wr(B + 32'h50, 32'd1);
    wr(B + 32'h8, 32'hDEAD_BEEF);
    check_eq("cfg2_wenb", 32'(cap_wenb), 32'h1);
    check_eq("cfg2_sel", cap_sel, 32'd2);
    rd(B + 32'h50);
    check_eq("cfg2_wenb_drop", 32'(cap_wenb), 32'h0);
    wr(B + 32'h48, 32'h1);
    check_eq("cfg18_wenb", 32'(cap_wenb), 32'h0);
    check_eq("cfg18_sel", cap_sel, 32'd17);

    // Normal completion after 10 cycles
    wr(B + 32'h5C, 32'd0);
    wr(B + 32'h50, 32'd2);
    run_idle(10, 1'b0);
    run_idle(1, 1'b1);
    rd(B + 32'h58);
    check_eq("fin_cycle", cap_rdata, 32'd10);
    check_eq("fin_irq", 32'(cap_irq), 32'(IRQ_EN));
    rd(B + 32'h54);
    check_eq("fin_status", cap_rdata, IRQ_EN ? 32'd3 : 32'd2);
    wr(B + 32'h50, 32'd4);
    rd(B + 32'h50);
    check_eq("cmd4_state", cap_rdata, 32'd3);
    check_eq("cmd4_irq", 32'(cap_irq), 32'h0);

    // Timeout after exactly 5 RUN cycles
    wr(B + 32'h50, 32'd0);
    wr(B + 32'h5C, 32'd5);
    wr(B + 32'h50, 32'd2);
    run_idle(4, 1'b0);
    rd(B + 32'h50);
    check_eq("to_still_run", cap_rdata, 32'd2);
    rd(B + 32'h50);
    check_eq("to_state", cap_rdata, 32'd4);
    check_eq("to_enb", 32'(cap_enb), 32'h0);
    rd(B + 32'h54);
    check_eq("to_flag", (cap_rdata >> 2) & 32'h1, 32'h1);

    // CTRL write beats cal_fin; cal_fin beats timeout
    wr(B + 32'h50, 32'd0);
    wr(B + 32'h50, 32'd2);
    step(1'b0, 1'b1, B + 32'h50, 32'd0, B + 32'h50, 1'b1);
    rd(B + 32'h50);
    check_eq("cmd_vs_fin_state", cap_rdata, 32'd0);
    rd(B + 32'h54);
    check_eq("cmd_vs_fin_flag", cap_rdata, 32'd0);
    wr(B + 32'h50, 32'd2);
    run_idle(4, 1'b0);
    run_idle(1, 1'b1);
    rd(B + 32'h50);
    check_eq("fin_vs_to_state", cap_rdata, 32'd3);

    // Reset in the middle of RUN
    wr(B + 32'h50, 32'd0);
    wr(B + 32'h5C, 32'd100);
    wr(B + 32'h50, 32'd2);
    run_idle(7, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, B + 32'h58, 1'b0);
    check_eq("pre_rst_cycle", cap_rdata, 32'd7);
    rd(B + 32'h58);
    check_eq("post_rst_cycle", cap_rdata, 32'd0);
    check_eq("post_rst_irq", 32'(cap_irq), 32'h0);
    check_eq("post_rst_rstn", 32'(cap_rstn), 32'h0);
    rd(B + 32'h5C);
    check_eq("post_rst_tlimit", cap_rdata, 32'd0);
    rd(B + 32'h50);
    check_eq("post_rst_state", cap_rdata, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0:       wa = B + 32'(4 * $urandom_range(0, 20));
        1, 7:    wa = B + 32'h50;
        2:       wa = B + 32'h54;
        3:       wa = B + 32'h58;
        4:       wa = B + 32'h5C;
        5:       wa = B + 32'($urandom_range(0, 32'h60));
        default: wa = $urandom;
      endcase
      if (wa == B + 32'h5C)    wd = 32'($urandom_range(0, 12));
      else if ($urandom_range(0, 3) == 0) wd = $urandom;
      else                     wd = 32'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = B + 32'h50;
        1:       ra = B + 32'h54;
        2:       ra = B + 32'h58;
        3:       ra = B + 32'h5C;
        4:       ra = B + 32'($urandom_range(0, 32'h64));
        default: ra = $urandom;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, wa, wd, ra,
           $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
